// File: rtl/axi_10g_ethernet_0_cdc_handshake_tx.sv
// Source-domain end of a toggle req/ack clock-domain crossing for one multi-bit word.
// A word is captured on valid/ready and held stable until the resynchronised ack matches the request.
module axi_10g_ethernet_0_cdc_handshake_tx #(
    parameter int C_DATA_WIDTH     = 32,
    parameter int C_NUM_SYNC_REGS  = 3,
    parameter int C_TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [C_DATA_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [C_DATA_WIDTH-1:0] xfer_data,
    output logic                    req_toggle,
    input  logic                    ack_toggle,
    output logic                    done,
    output logic                    busy,
    output logic                    timeout_err,
    output logic                    proto_err,
    input  logic                    clr_err
);

    localparam bit TO_EN = (C_TIMEOUT_CYCLES != 0);
    localparam int TW    = TO_EN ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_SAT = TW'(C_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LIM = TW'(TO_EN ? C_TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic          ack_s;
    logic          match;
    logic          accept;
    logic          done_nxt;
    logic          to_set;
    logic          pe_set;

    // Metastability chain: kept as discrete flops so tools neither pack it into an SRL nor retime it.
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [C_NUM_SYNC_REGS-1:0] ack_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[C_NUM_SYNC_REGS-2:0], ack_toggle};
        end
    end

    assign ack_s   = ack_sync[C_NUM_SYNC_REGS-1];
    assign match   = (ack_s == req_toggle);
    assign s_ready = (state == IDLE) && match;
    assign accept  = s_valid && s_ready;
    assign busy    = (state == WAIT_ACK);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        done_nxt  = 1'b0;
        to_set    = 1'b0;
        pe_set    = 1'b0;
        case (state)
            IDLE: begin
                if (!match) begin
                    pe_set = 1'b1;
                end
                if (accept) begin
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (match) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (TO_EN && (timer >= T_LIM)) begin
                    to_set = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            xfer_data   <= '0;
            req_toggle  <= 1'b0;
            timer       <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (accept) begin
                xfer_data  <= s_data;
                req_toggle <= ~req_toggle;
                timer      <= '0;
            end else if ((state == WAIT_ACK) && (timer != T_SAT)) begin
                timer <= timer + TW'(1);
            end
            // Set has priority over a simultaneous clear.
            timeout_err <= to_set | (timeout_err & ~clr_err);
            proto_err   <= pe_set | (proto_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_axi_10g_ethernet_0_cdc_handshake_tx.sv
// Directed bench for the toggle-handshake CDC source: scoreboard of accepted words,
// ack latency, timeout, protocol error and asynchronous reset behaviour.
module tb_axi_10g_ethernet_0_cdc_handshake_tx;

    localparam int W    = 32;
    localparam int SYNC = 3;
    localparam int TO   = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] xfer_data;
    logic         req_toggle;
    logic         ack_toggle;
    logic         done;
    logic         busy;
    logic         timeout_err;
    logic         proto_err;
    logic         clr_err;

    logic         man_ack;
    logic         lb_en;
    logic [1:0]   lb_pipe = 2'b00;

    int           n_cmp = 0;
    int           n_err = 0;
    logic         exp_req;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] held;

    axi_10g_ethernet_0_cdc_handshake_tx #(
        .C_DATA_WIDTH    (W),
        .C_NUM_SYNC_REGS (SYNC),
        .C_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .xfer_data  (xfer_data),
        .req_toggle (req_toggle),
        .ack_toggle (ack_toggle),
        .done       (done),
        .busy       (busy),
        .timeout_err(timeout_err),
        .proto_err  (proto_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    // Destination loopback model: ack follows req about two cycles later.
    always @(negedge clk) lb_pipe = {lb_pipe[0], req_toggle};
    assign ack_toggle = lb_en ? lb_pipe[1] : man_ack;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one word, return the ack 5 cycles later, expect done SYNC+1 edges after that.
    task automatic single_xfer(input logic [W-1:0] w);
        check("ready_before", s_ready, 1);
        s_data  = w;
        s_valid = 1'b1;
        sb_q.push_back(w);
        step();
        s_valid = 1'b0;
        exp_req = ~exp_req;
        check("req_after_accept", req_toggle, exp_req);
        check("busy_after_accept", busy, 1);
        check("ready_low_busy", s_ready, 0);
        check("xfer_data", xfer_data, sb_q.pop_front());
        repeat (5) step();
        man_ack = exp_req;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("done_k%0d", k), done, (k == SYNC + 1) ? 1 : 0);
            if (k == SYNC + 1) begin
                check("ready_on_done", s_ready, 1);
                check("busy_on_done", busy, 0);
            end
        end
    endtask

    initial begin
        int   first_k;
        int   extra;
        int   n_acc;
        int   budget;
        logic prev_done;
        logic [W-1:0] words[4];
        words = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        clr_err = 1'b0;
        man_ack = 1'b0;
        lb_en   = 1'b0;
        exp_req = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_xfer_data", xfer_data, 0);
        check("rst_req", req_toggle, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_proto", proto_err, 0);
        check("rst_ready", s_ready, 1);

        // 1: single transfer
        single_xfer(32'hA5A5_0001);

        // 2: back-to-back words with looped-back ack
        lb_en   = 1'b1;
        n_acc   = 0;
        s_data  = words[0];
        s_valid = 1'b1;
        sb_q.push_back(words[0]);
        prev_done = done;
        while (n_acc < 4) begin
            budget = 0;
            while (req_toggle === exp_req && budget < 40) begin
                prev_done = done;
                step();
                budget++;
            end
            if (budget >= 40) begin
                check("b2b_accept_timeout", budget, 0);
                break;
            end
            exp_req = ~exp_req;
            check($sformatf("b2b_data%0d", n_acc), xfer_data, sb_q.pop_front());
            if (n_acc > 0) check($sformatf("b2b_done_with_accept%0d", n_acc), prev_done, 1);
            n_acc++;
            if (n_acc < 4) begin
                s_data = words[n_acc];
                sb_q.push_back(words[n_acc]);
            end else begin
                s_valid = 1'b0;
            end
        end
        extra = 0;
        repeat (20) begin
            step();
            if (req_toggle !== exp_req) extra++;
        end
        check("b2b_no_extra_toggle", extra, 0);
        check("b2b_scoreboard_empty", sb_q.size(), 0);
        check("b2b_idle_ready", s_ready, 1);
        man_ack = exp_req;
        lb_en   = 1'b0;
        step();

        // 3 + 4: timeout while waiting, s_valid ignored in WAIT_ACK
        s_data  = 32'h0BAD_CAFE;
        s_valid = 1'b1;
        sb_q.push_back(32'h0BAD_CAFE);
        step();
        s_valid = 1'b0;
        exp_req = ~exp_req;
        held    = sb_q.pop_front();
        check("to_xfer_data", xfer_data, held);
        first_k = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (timeout_err === 1'b1 && first_k < 0) first_k = k;
            if (k == 3) begin
                s_data  = 32'hDEAD_BEEF;
                s_valid = 1'b1;
            end
            if (k == 4) s_valid = 1'b0;
            if (k == 6) begin
                check("wait_xfer_stable", xfer_data, held);
                check("wait_no_req_toggle", req_toggle, exp_req);
            end
        end
        check("timeout_cycle", first_k, TO);
        man_ack = exp_req;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("to_done_k%0d", k), done, (k == SYNC + 1) ? 1 : 0);
        end
        check("timeout_sticky", timeout_err, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("timeout_cleared", timeout_err, 0);
        check("proto_still_clear", proto_err, 0);

        // 5: spurious ack in IDLE
        man_ack = ~exp_req;
        step();
        step();
        check("pe_ready_before_sync", s_ready, 1);
        step();
        check("pe_ready_low", s_ready, 0);
        check("pe_not_yet", proto_err, 0);
        step();
        check("pe_set", proto_err, 1);
        man_ack = exp_req;
        step();
        step();
        check("pe_ready_still_low", s_ready, 0);
        step();
        check("pe_ready_restored", s_ready, 1);
        check("pe_sticky", proto_err, 1);
        check("pe_no_req_change", req_toggle, exp_req);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("pe_cleared", proto_err, 0);

        // 6: asynchronous reset mid WAIT_ACK
        s_data  = 32'hA5A5_0002;
        s_valid = 1'b1;
        sb_q.push_back(32'hA5A5_0002);
        step();
        s_valid = 1'b0;
        exp_req = ~exp_req;
        check("rst6_xfer_data", xfer_data, sb_q.pop_front());
        repeat (3) step();
        #3;
        rst_n   = 1'b0;
        man_ack = 1'b0;
        #1;
        check("arst_req", req_toggle, 0);
        check("arst_xfer_data", xfer_data, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_timeout", timeout_err, 0);
        check("arst_proto", proto_err, 0);
        check("arst_ready", s_ready, 1);
        exp_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        single_xfer(32'hA5A5_0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
